// File: rtl/ifu_fetch_pkg.sv
// ============================================================================
// Module  : ifu_fetch_pkg
// Brief   : Shared types and defaults for the instruction-fetch front end.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package ifu_fetch_pkg;

    localparam int          IFU_CPU_WIDTH  = 64;
    localparam logic [63:0] IFU_RESET_PC   = 64'h8000_0000;
    localparam int          IFU_INST_W     = 32;
    localparam int          IFU_INST_BYTES = 4;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2,
        S_HOLD = 2'd3
    } ifu_state_e;

endpackage

`default_nettype wire

// File: rtl/ifu_redir_arb.sv
// ============================================================================
// Module  : ifu_redir_arb
// Brief   : Fixed-priority redirect select: fence > iru > bru.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ifu_redir_arb #(
    parameter int CPU_WIDTH = 64
) (
    input  logic                 i_fence_jump,
    input  logic [CPU_WIDTH-1:0] i_fence_pc,
    input  logic                 i_iru_jump,
    input  logic [CPU_WIDTH-1:0] i_iru_pc,
    input  logic                 i_bru_jump,
    input  logic [CPU_WIDTH-1:0] i_bru_pc,
    output logic                 o_redir,
    output logic [CPU_WIDTH-1:0] o_redir_pc
);

    always_comb begin
        o_redir    = i_fence_jump | i_iru_jump | i_bru_jump;
        o_redir_pc = i_bru_pc;
        if (i_fence_jump) begin
            o_redir_pc = i_fence_pc;
        end else if (i_iru_jump) begin
            o_redir_pc = i_iru_pc;
        end
    end

endmodule

`default_nettype wire

// File: rtl/stl_reg.sv
// ============================================================================
// Module  : stl_reg
// Brief   : Enabled register with synchronous active-high reset.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module stl_reg #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_q <= RESET_VAL;
        end else if (i_en) begin
            o_q <= i_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ifu_fetch.sv
// ============================================================================
// Module  : ifu_fetch
// Brief   : Fetch PC owner; one outstanding I-mem request, redirect/kill, IDU handoff.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter int                   CPU_WIDTH = IFU_CPU_WIDTH,
    parameter logic [CPU_WIDTH-1:0] RESET_PC  = CPU_WIDTH'(IFU_RESET_PC)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_fence_jump,
    input  logic [CPU_WIDTH-1:0]  i_fence_pc,
    input  logic                  i_iru_jump,
    input  logic [CPU_WIDTH-1:0]  i_iru_pc,
    input  logic                  i_bru_jump,
    input  logic [CPU_WIDTH-1:0]  i_bru_pc,
    output logic                  o_req_valid,
    output logic [CPU_WIDTH-1:0]  o_req_addr,
    input  logic                  i_req_ready,
    input  logic                  i_rsp_valid,
    input  logic [IFU_INST_W-1:0] i_rsp_inst,
    output logic                  o_if_valid,
    output logic [CPU_WIDTH-1:0]  o_if_pc,
    output logic [IFU_INST_W-1:0] o_if_inst,
    input  logic                  i_id_ready
);

    localparam logic [CPU_WIDTH-1:0] c_PC_STEP = CPU_WIDTH'(IFU_INST_BYTES);

    logic                  w_redir;
    logic [CPU_WIDTH-1:0]  w_redir_pc;

    logic [1:0]            r_state_bits;
    ifu_state_e            w_state;
    logic [CPU_WIDTH-1:0]  r_pc_q;
    logic [CPU_WIDTH-1:0]  r_tgt_q;
    logic                  r_tgt_pend;
    logic [CPU_WIDTH-1:0]  r_buf_pc;
    logic [IFU_INST_W-1:0] r_buf_inst;

    ifu_state_e            w_state_nxt;
    logic                  w_pc_en;
    logic [CPU_WIDTH-1:0]  w_pc_nxt;
    logic                  w_tgt_en;
    logic                  w_pend_en;
    logic                  w_pend_nxt;
    logic                  w_buf_en;
    logic                  w_req_valid;
    logic                  w_if_valid;

    ifu_redir_arb #(
        .CPU_WIDTH (CPU_WIDTH)
    ) u_redir_arb (
        .i_fence_jump (i_fence_jump),
        .i_fence_pc   (i_fence_pc),
        .i_iru_jump   (i_iru_jump),
        .i_iru_pc     (i_iru_pc),
        .i_bru_jump   (i_bru_jump),
        .i_bru_pc     (i_bru_pc),
        .o_redir      (w_redir),
        .o_redir_pc   (w_redir_pc)
    );

    assign w_state = ifu_state_e'(r_state_bits);

    always_comb begin
        w_state_nxt = w_state;
        w_pc_en     = 1'b0;
        w_pc_nxt    = r_pc_q;
        w_tgt_en    = 1'b0;
        w_pend_en   = 1'b0;
        w_pend_nxt  = r_tgt_pend;
        w_buf_en    = 1'b0;
        w_req_valid = 1'b0;
        w_if_valid  = 1'b0;

        case (w_state)
            S_REQ: begin
                w_req_valid = 1'b1;
                // A redirect seen while the request is outstanding at the port
                // is remembered; the old-path request still goes out unchanged.
                if (w_redir) begin
                    w_tgt_en   = 1'b1;
                    w_pend_en  = 1'b1;
                    w_pend_nxt = 1'b1;
                end
                if (i_req_ready) begin
                    w_state_nxt = (w_redir || r_tgt_pend) ? S_DROP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_rsp_valid) begin
                    w_pc_en = 1'b1;
                    if (w_redir) begin
                        w_pc_nxt    = w_redir_pc;
                        w_state_nxt = S_REQ;
                    end else begin
                        w_buf_en    = 1'b1;
                        w_pc_nxt    = r_pc_q + c_PC_STEP;
                        w_state_nxt = S_HOLD;
                    end
                end else if (w_redir) begin
                    w_tgt_en    = 1'b1;
                    w_pend_en   = 1'b1;
                    w_pend_nxt  = 1'b1;
                    w_state_nxt = S_DROP;
                end
            end
            S_DROP: begin
                if (i_rsp_valid) begin
                    w_pc_en     = 1'b1;
                    w_pc_nxt    = w_redir ? w_redir_pc : r_tgt_q;
                    w_pend_en   = 1'b1;
                    w_pend_nxt  = 1'b0;
                    w_state_nxt = S_REQ;
                end else if (w_redir) begin
                    w_tgt_en = 1'b1;
                end
            end
            S_HOLD: begin
                // Same-cycle redirect kills the wrong-path instruction.
                w_if_valid = ~w_redir;
                if (w_redir) begin
                    w_pc_en     = 1'b1;
                    w_pc_nxt    = w_redir_pc;
                    w_state_nxt = S_REQ;
                end else if (i_id_ready) begin
                    w_state_nxt = S_REQ;
                end
            end
            default: begin
                w_state_nxt = S_REQ;
            end
        endcase
    end

    stl_reg #(.WIDTH(2), .RESET_VAL(2'(S_REQ))) u_state_reg (
        .i_clk (i_clk), .i_rst (i_rst), .i_en (1'b1),
        .i_d   (2'(w_state_nxt)), .o_q (r_state_bits)
    );

    stl_reg #(.WIDTH(CPU_WIDTH), .RESET_VAL(RESET_PC)) u_pc_reg (
        .i_clk (i_clk), .i_rst (i_rst), .i_en (w_pc_en),
        .i_d   (w_pc_nxt), .o_q (r_pc_q)
    );

    stl_reg #(.WIDTH(CPU_WIDTH), .RESET_VAL('0)) u_tgt_reg (
        .i_clk (i_clk), .i_rst (i_rst), .i_en (w_tgt_en),
        .i_d   (w_redir_pc), .o_q (r_tgt_q)
    );

    stl_reg #(.WIDTH(1), .RESET_VAL(1'b0)) u_pend_reg (
        .i_clk (i_clk), .i_rst (i_rst), .i_en (w_pend_en),
        .i_d   (w_pend_nxt), .o_q (r_tgt_pend)
    );

    stl_reg #(.WIDTH(CPU_WIDTH), .RESET_VAL('0)) u_buf_pc_reg (
        .i_clk (i_clk), .i_rst (i_rst), .i_en (w_buf_en),
        .i_d   (r_pc_q), .o_q (r_buf_pc)
    );

    stl_reg #(.WIDTH(IFU_INST_W), .RESET_VAL('0)) u_buf_inst_reg (
        .i_clk (i_clk), .i_rst (i_rst), .i_en (w_buf_en),
        .i_d   (i_rsp_inst), .o_q (r_buf_inst)
    );

    // Outputs are forced to their reset values during the reset cycle itself.
    assign o_req_valid = w_req_valid & ~i_rst;
    assign o_req_addr  = i_rst ? RESET_PC : r_pc_q;
    assign o_if_valid  = w_if_valid & ~i_rst;
    assign o_if_pc     = i_rst ? '0 : r_buf_pc;
    assign o_if_inst   = i_rst ? '0 : r_buf_inst;

endmodule

`default_nettype wire
